// File: rtl/arith_unit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : arith_unit_seq_if
//  Description : Operand/result bus of the sequential arithmetic unit.
//                The master (upstream sequencer) presents operands with a
//                valid/ready handshake. The slave (arith_unit_seq) returns a
//                one-cycle result strobe with held Q/overflow.
//  Signals     : in_valid  - operand/op present          (master -> slave)
//                in_ready  - unit can accept              (slave  -> master)
//                A, B      - two's complement operands    (master -> slave)
//                sel       - 00 add, 01 sub, 10 mul, 11 accumulate
//                acc_clear - synchronous accumulator clear
//                out_valid - one-cycle result strobe      (slave  -> master)
//                Q         - result, held between strobes
//                overflow  - exact result not representable, held with Q
//  Revision    : 1.0  initial release
// ============================================================================
interface arith_unit_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       sel;
    logic             acc_clear;
    logic             out_valid;
    logic [WIDTH-1:0] Q;
    logic             overflow;

    modport master (
        output in_valid, A, B, sel, acc_clear,
        input  in_ready, out_valid, Q, overflow
    );

    modport slave (
        input  in_valid, A, B, sel, acc_clear,
        output in_ready, out_valid, Q, overflow
    );
endinterface
`default_nettype wire

// File: rtl/arith_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : arith_unit_seq
//  Description : Registered arithmetic unit: add, subtract, multi-cycle
//                shift-add signed multiply and a running accumulator, with a
//                wrap (SATURATE=0) or clamp (SATURATE=1) overflow policy.
//  Ports       : clk - system clock, rising edge
//                rst - synchronous reset, active-high
//                bus - arith_unit_seq_if.slave (operands in, result out)
//  Parameters  : WIDTH    - operand/result width, two's complement, >= 2
//                SATURATE - 0 wrap, 1 clamp to MAX/MIN on overflow
//  Revision    : 1.0  initial release
// ============================================================================
module arith_unit_seq #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input wire logic        clk,
    input wire logic        rst,
    arith_unit_seq_if.slave bus
);
    localparam int c_pw = 2 * WIDTH;
    localparam int c_cw = $clog2(WIDTH);
    localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0]  c_one  = c_cw'(1);
    localparam logic [WIDTH-1:0] c_max  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_mul = 2'b10;
    localparam logic [1:0] c_op_acc = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             ov_q;
    logic             vld_q;
    logic [WIDTH-1:0] acc_q;
    logic [c_pw-1:0]  mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [c_pw-1:0]  prod_q;
    logic             neg_q;
    logic [c_cw-1:0]  cnt_q;

    // Takes an exact result sign-extended to 2*WIDTH bits, returns {ov, Q}.
    // The value fits iff every bit from the WIDTH-1 sign position upwards
    // matches the top bit.
    function automatic logic [WIDTH:0] f_policy(input logic [c_pw-1:0] x);
        logic             ovf;
        logic [WIDTH-1:0] r;
        ovf = (x[c_pw-1:WIDTH-1] != {(c_pw-WIDTH+1){x[c_pw-1]}});
        r   = x[WIDTH-1:0];
        if (SATURATE && ovf) begin
            r = x[c_pw-1] ? c_min : c_max;
        end
        return {ovf, r};
    endfunction

    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH:0]   w_sum;
    logic [c_pw-1:0]  w_sum_wide;
    logic [WIDTH:0]   w_res_alu;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [c_pw-1:0]  w_partial;
    logic [c_pw-1:0]  w_prod;
    logic [WIDTH:0]   w_res_mul;

    assign w_ready  = (state_q == ST_IDLE) && !rst;
    assign w_accept = bus.in_valid && w_ready;

    // A coincident clear wins over the stored value, so clear+accumulate
    // yields policy(0 + A).
    assign w_acc_base = bus.acc_clear ? '0 : acc_q;

    // Exact add/sub/accumulate at WIDTH+1 bits, which cannot overflow.
    always_comb begin
        w_sum = '0;
        case (bus.sel)
            c_op_add: w_sum = {bus.A[WIDTH-1], bus.A} + {bus.B[WIDTH-1], bus.B};
            c_op_sub: w_sum = {bus.A[WIDTH-1], bus.A} - {bus.B[WIDTH-1], bus.B};
            default:  w_sum = {w_acc_base[WIDTH-1], w_acc_base} + {bus.A[WIDTH-1], bus.A};
        endcase
    end

    assign w_sum_wide = {{(c_pw-WIDTH-1){w_sum[WIDTH]}}, w_sum};
    assign w_res_alu  = f_policy(w_sum_wide);

    // Unsigned magnitudes: negating MIN gives 100..0, which read unsigned
    // is exactly abs(MIN).
    assign w_mag_a = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    assign w_mag_b = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

    // One multiplier bit per cycle; the last partial sum is the full
    // magnitude product, negated when the operand signs differ.
    assign w_partial = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign w_prod    = neg_q ? (~w_partial + 1'b1) : w_partial;
    assign w_res_mul = f_policy(w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            ov_q     <= 1'b0;
            vld_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            vld_q <= 1'b0;
            if (bus.acc_clear) begin
                acc_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.sel == c_op_mul) begin
                            state_q  <= ST_MUL;
                            mcand_q  <= {{WIDTH{1'b0}}, w_mag_a};
                            mplier_q <= w_mag_b;
                            prod_q   <= '0;
                            neg_q    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            cnt_q    <= '0;
                        end else begin
                            q_q   <= w_res_alu[WIDTH-1:0];
                            ov_q  <= w_res_alu[WIDTH];
                            vld_q <= 1'b1;
                            if (bus.sel == c_op_acc) begin
                                acc_q <= w_res_alu[WIDTH-1:0];
                            end
                        end
                    end
                end
                ST_MUL: begin
                    prod_q   <= w_partial;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + c_one;
                    if (cnt_q == c_last) begin
                        state_q <= ST_IDLE;
                        q_q     <= w_res_mul[WIDTH-1:0];
                        ov_q    <= w_res_mul[WIDTH];
                        vld_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = vld_q;
    assign bus.Q         = q_q;
    assign bus.overflow  = ov_q;
endmodule
`default_nettype wire

// File: tb/tb_arith_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_unit_seq
//  Description : Self-checking bench for arith_unit_seq at WIDTH=4. Two
//                instances (wrap and saturate) receive identical stimulus.
//                Directed vectors with hand-computed results, then a full
//                (sel,A,B) sweep against a small integer reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arith_unit_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    arith_unit_seq_if #(.WIDTH(W)) if0 ();
    arith_unit_seq_if #(.WIDTH(W)) if1 ();

    arith_unit_seq #(.WIDTH(W), .SATURATE(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    arith_unit_seq #(.WIDTH(W), .SATURATE(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] s, input logic [3:0] a,
                          input logic [3:0] b, input logic c);
        if0.in_valid = v; if0.sel = s; if0.A = a; if0.B = b; if0.acc_clear = c;
        if1.in_valid = v; if1.sel = s; if1.A = a; if1.B = b; if1.acc_clear = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_vld0"}, if0.out_valid, 1'b0);
        chk_eq({tag, "_vld1"}, if1.out_valid, 1'b0);
    endtask

    // Issue one op, honour its latency, then check the strobe cycle.
    // During a multiply in_valid stays high with sel=add; it must be ignored.
    task automatic run_op(input string tag, input logic [1:0] s, input logic [3:0] a,
                          input logic [3:0] b, input logic c,
                          input logic [3:0] q0, input logic ov0,
                          input logic [3:0] q1, input logic ov1);
        set_in(1'b1, s, a, b, c);
        step();
        if (s == 2'b10) begin
            set_in(1'b1, 2'b00, a, b, 1'b0);
            for (int k = 0; k < W - 1; k++) begin
                chk_eq({tag, "_busy_rdy"}, {if0.in_ready, if1.in_ready}, 2'b00);
                chk_idle({tag, "_busy"});
                step();
            end
            step();
        end
        set_in(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        chk_eq({tag, "_vld"}, {if0.out_valid, if1.out_valid}, 2'b11);
        chk_eq({tag, "_rdy"}, {if0.in_ready, if1.in_ready}, 2'b11);
        chk_eq({tag, "_q0"},  if0.Q, q0);
        chk_eq({tag, "_ov0"}, if0.overflow, ov0);
        chk_eq({tag, "_q1"},  if1.Q, q1);
        chk_eq({tag, "_ov1"}, if1.overflow, ov1);
    endtask

    // Reference: exact integer result, then wrap or clamp. Accumulate in the
    // sweep always clears, so its exact value is just A.
    function automatic logic [4:0] f_ref(input logic [1:0] s, input logic [3:0] a,
                                         input logic [3:0] b, input bit sat);
        int         ia, ib, ex;
        logic       ov;
        logic [3:0] q;
        ia = $signed(a);
        ib = $signed(b);
        case (s)
            2'b00:   ex = ia + ib;
            2'b01:   ex = ia - ib;
            2'b10:   ex = ia * ib;
            default: ex = ia;
        endcase
        ov = (ex > 7) || (ex < -8);
        q  = ex[3:0];
        if (sat && ov) q = (ex > 7) ? 4'h7 : 4'h8;
        return {ov, q};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [4:0] r0, r1;

        // Reset
        rst = 1'b1;
        set_in(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        #1;
        chk_eq("rst_rdy", {if0.in_ready, if1.in_ready}, 2'b00);
        step();
        step();
        rst = 1'b0;
        #1;
        chk_eq("rst_rdy_up", {if0.in_ready, if1.in_ready}, 2'b11);
        chk_idle("rst");
        chk_eq("rst_q", {if0.Q, if1.Q}, 8'h00);
        chk_eq("rst_ov", {if0.overflow, if1.overflow}, 2'b00);

        // Add/sub overflow, both policies
        run_op("add7p1",  2'b00, 4'h7, 4'h1, 1'b0, 4'h8, 1'b1, 4'h7, 1'b1);
        run_op("subm8m1", 2'b01, 4'h8, 4'h1, 1'b0, 4'h7, 1'b1, 4'h8, 1'b1);
        run_op("add3m5",  2'b00, 4'h3, 4'hB, 1'b0, 4'hE, 1'b0, 4'hE, 1'b0);

        // Three accepts on consecutive edges -> three consecutive strobes
        set_in(1'b1, 2'b00, 4'h1, 4'h2, 1'b0);
        step();
        chk_eq("b2b1_vld", {if0.out_valid, if1.out_valid}, 2'b11);
        chk_eq("b2b1_q", {if0.Q, if1.Q}, 8'h33);
        set_in(1'b1, 2'b01, 4'h2, 4'h5, 1'b0);
        step();
        chk_eq("b2b2_vld", {if0.out_valid, if1.out_valid}, 2'b11);
        chk_eq("b2b2_q", {if0.Q, if1.Q}, 8'hDD);
        set_in(1'b1, 2'b00, 4'hC, 4'hC, 1'b0);
        step();
        chk_eq("b2b3_vld", {if0.out_valid, if1.out_valid}, 2'b11);
        chk_eq("b2b3_q", {if0.Q, if1.Q}, 8'h88);
        chk_eq("b2b3_ov", {if0.overflow, if1.overflow}, 2'b00);
        set_in(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        step();
        chk_idle("b2b_end");

        // Multiply latency, ignored in_valid during MUL, no extra strobe
        run_op("mul3m2", 2'b10, 4'h3, 4'hE, 1'b0, 4'hA, 1'b0, 4'hA, 1'b0);
        step();
        chk_idle("mul3m2_after");
        chk_eq("mul3m2_hold", {if0.Q, if1.Q}, 8'hAA);
        run_op("mulm8m8", 2'b10, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 4'h7, 1'b1);

        // Accumulator
        set_in(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        step();
        chk_idle("accclr");
        run_op("acc5a",  2'b11, 4'h5, 4'h0, 1'b0, 4'h5, 1'b0, 4'h5, 1'b0);
        run_op("acc5b",  2'b11, 4'h5, 4'h0, 1'b0, 4'hA, 1'b1, 4'h7, 1'b1);
        run_op("acc2cl", 2'b11, 4'h2, 4'h0, 1'b1, 4'h2, 1'b0, 4'h2, 1'b0);

        // Reset during a multiply: aborted, no strobe
        set_in(1'b1, 2'b10, 4'h7, 4'h7, 1'b0);
        step();
        set_in(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        chk_idle("rmul_n");
        step();
        chk_idle("rmul_n1");
        rst = 1'b1;
        #1;
        chk_eq("rmul_rdy_rst", {if0.in_ready, if1.in_ready}, 2'b00);
        step();
        rst = 1'b0;
        #1;
        chk_eq("rmul_rdy", {if0.in_ready, if1.in_ready}, 2'b11);
        chk_eq("rmul_q", {if0.Q, if1.Q}, 8'h00);
        chk_eq("rmul_ov", {if0.overflow, if1.overflow}, 2'b00);
        for (int k = 0; k < 2 * W; k++) begin
            chk_idle("rmul_quiet");
            step();
        end
        run_op("rmul_add", 2'b00, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 4'h2, 1'b0);

        // Full sweep against the reference model
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    r0 = f_ref(2'(s), 4'(a), 4'(b), 1'b0);
                    r1 = f_ref(2'(s), 4'(a), 4'(b), 1'b1);
                    run_op($sformatf("sw_s%0d_a%0d_b%0d", s, a, b), 2'(s), 4'(a), 4'(b),
                           (s == 3), r0[3:0], r0[4], r1[3:0], r1[4]);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
Parametrised, registered successor to the 4-bit combinational arithmetic unit. Supports add, subtract, multi-cycle signed multiply and a running accumulator, with a valid/ready input handshake, a one-cycle output strobe, and a selectable wrap or saturate overflow policy. It sits in the datapath as a shared arithmetic resource behind an upstream sequencer.

Parameters:
WIDTH, 8, operand/result width in bits, two's complement, minimum 2
SATURATE, 0, 0 = wrap on overflow; 1 = clamp to MAX=2^(WIDTH-1)-1 / MIN=-2^(WIDTH-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand/op present
in_ready  output  1  unit can accept; high only in IDLE and when rst is low
A  input  WIDTH  signed operand A
B  input  WIDTH  signed operand B (ignored for accumulate)
sel  input  2  00 add, 01 sub, 10 mul, 11 accumulate
acc_clear  input  1  synchronous accumulator clear
out_valid  output  1  one-cycle strobe: Q/overflow updated
Q  output  WIDTH  signed result, held between strobes
overflow  output  1  exact result not representable in WIDTH; held with Q

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, Q=0, overflow=0, out_valid=0, acc=0. An in-flight multiply is aborted and produces no strobe. in_ready=0 while rst=1.
- Accept: in_valid & in_ready at edge N. in_valid is ignored while in_ready=0; no queueing.
- FSM states: IDLE and MUL. IDLE->MUL on an accepted sel=10. MUL->IDLE after WIDTH cycles in MUL. All other ops stay in IDLE.
- Add/sub/accumulate: result registered at edge N; out_valid=1 for the cycle after N; back-to-back accepts every cycle are allowed.
- Add/sub: exact result is computed at WIDTH+1 bits. Overflow = exact value outside [MIN, MAX].
- Accumulate: exact = acc + A. Q and the new acc = the policy-applied value, so acc never leaves range.
- acc_clear: sets acc=0 at the edge. If it coincides with an accepted accumulate, the clear applies first, so acc = Q = policy(0 + A). acc_clear produces no out_valid.
- Multiply: shift-add on WIDTH-bit magnitudes, one bit per cycle. The 2*WIDTH-bit product is sign-corrected at the end. abs(MIN) must be handled correctly (unsigned magnitude).
  - Operands are latched at edge N and in_ready=0 for WIDTH cycles.
  - Q is registered at edge N+WIDTH; out_valid=1 for the cycle after N+WIDTH, and in_ready=1 again in that same cycle.
  - Overflow = full product outside [MIN, MAX].
- Policy: SATURATE=0 gives Q = low WIDTH bits of the exact result. SATURATE=1 gives Q = MAX on positive overflow, MIN on negative overflow. overflow is flagged in both modes.
- out_valid is never high two cycles in a row for a multiply. Q and overflow change only on strobe edges or reset.

Test Plan:
- WIDTH=4, SATURATE=0: add A=7,B=1 -> next cycle out_valid=1, Q=-8, ov=1. sub A=-8,B=1 -> Q=7, ov=1. add 3,-5 -> Q=-2, ov=0. Issue one accept per cycle for three cycles -> three consecutive strobes.
- WIDTH=4, SATURATE=1: add 7+1 -> Q=7, ov=1. sub -8-1 -> Q=-8, ov=1. mul -8*-8 -> Q=7, ov=1.
- WIDTH=4: mul A=3,B=-2 accepted at edge N -> in_ready=0 for 4 cycles, out_valid only in the cycle after N+4, Q=-6, ov=0. in_valid held high with sel=00 during MUL -> ignored, no extra strobe. Also mul -8*-8 with SATURATE=0 -> Q=0, ov=1.
- Accumulator, WIDTH=4, SATURATE=0: acc_clear, then accumulate 5, 5 -> Q=5 ov=0, then Q=-6 ov=1. Next, accumulate 2 with acc_clear high in the same cycle -> Q=2.
- Reset mid-multiply: accept mul 7*7, assert rst 2 cycles later -> no out_valid ever, Q=0, ov=0. in_ready=1 the cycle after rst drops, and the next add 1+1 -> Q=2.
- Exhaustive sweep, WIDTH=4, both SATURATE values: all 1024 (sel,A,B) combinations, compared against a reference model including latency.
